// File: rtl/gp9001_cpu_port_if.sv
// rtl/gp9001_cpu_port_if.sv - 68K->GP9001 command bus with 4-phase CS/ACK handshake
interface gp9001_cpu_port_if;
    logic        cs;
    logic [15:0] din;
    logic        op_select_reg;
    logic        op_write_reg;
    logic        op_set_ram_ptr;
    logic        op_write_ram;
    logic        op_read_ram_h;
    logic        op_read_ram_l;
    logic        ack;
    logic [15:0] dout;

    modport master (
        output cs, din, op_select_reg, op_write_reg, op_set_ram_ptr,
               op_write_ram, op_read_ram_h, op_read_ram_l,
        input  ack, dout
    );

    modport slave (
        input  cs, din, op_select_reg, op_write_reg, op_set_ram_ptr,
               op_write_ram, op_read_ram_h, op_read_ram_l,
        output ack, dout
    );
endinterface

// File: rtl/gp9001_cpu_port.sv
// rtl/gp9001_cpu_port.sv - GP9001 CPU port: op decode, GCU register file, VRAM pointer and access
module gp9001_cpu_port #(
    parameter int NREGS  = 16,
    parameter int AW     = 14,
    parameter int RD_LAT = 2
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    gp9001_cpu_port_if.slave      bus,
    output logic [16*NREGS-1:0]   o_reg_file,
    output logic                  o_reg_wr_stb,
    output logic [7:0]            o_reg_wr_idx,
    output logic [AW-1:0]         o_vram_addr,
    output logic [15:0]           o_vram_dout,
    output logic                  o_vram_we,
    output logic                  o_vram_rd,
    input  logic [15:0]           i_vram_din
);

    typedef enum logic [1:0] {ST_IDLE, ST_RDWAIT, ST_DONE} state_t;

    localparam logic [8:0]    NREGS_W = 9'(NREGS);
    localparam logic [2:0]    LAT_W   = 3'(RD_LAT);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);

    state_t        r_state;
    state_t        w_state_nxt;
    logic          r_ack;
    logic [15:0]   r_dout;
    logic [15:0]   r_regs [NREGS];
    logic          r_reg_wr_stb;
    logic [7:0]    r_reg_wr_idx;
    logic [7:0]    r_reg_idx;
    logic [AW-1:0] r_ptr;
    logic [2:0]    r_cnt;
    logic          r_rd_inc;

    logic [5:0]    w_ops;
    logic          w_req;
    logic          w_reg_ok;
    logic          w_sel;
    logic          w_wreg;
    logic          w_setp;
    logic          w_wram;
    logic          w_rd;

    assign w_ops = {bus.op_read_ram_l, bus.op_read_ram_h, bus.op_write_ram,
                    bus.op_set_ram_ptr, bus.op_write_reg, bus.op_select_reg};
    assign w_req    = bus.cs && !r_ack && (r_state == ST_IDLE) && !i_reset;
    assign w_reg_ok = ({1'b0, r_reg_idx} < NREGS_W);

    // Illegal op combinations still complete the handshake so the CPU bus never stalls.
    always_comb begin
        w_state_nxt = r_state;
        w_sel       = 1'b0;
        w_wreg      = 1'b0;
        w_setp      = 1'b0;
        w_wram      = 1'b0;
        w_rd        = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (w_req) begin
                    w_state_nxt = ST_DONE;
                    if ($onehot(w_ops)) begin
                        w_sel  = bus.op_select_reg;
                        w_wreg = bus.op_write_reg;
                        w_setp = bus.op_set_ram_ptr;
                        w_wram = bus.op_write_ram;
                        w_rd   = bus.op_read_ram_h | bus.op_read_ram_l;
                        if (w_rd) begin
                            w_state_nxt = ST_RDWAIT;
                        end
                    end
                end
            end
            ST_RDWAIT: begin
                if (r_cnt == LAT_W) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                if (!bus.cs) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state      <= ST_IDLE;
            r_ack        <= 1'b0;
            r_dout       <= 16'h0000;
            r_reg_wr_stb <= 1'b0;
            r_reg_wr_idx <= 8'h00;
            r_reg_idx    <= 8'h00;
            r_ptr        <= '0;
            r_cnt        <= 3'd0;
            r_rd_inc     <= 1'b0;
            for (int i = 0; i < NREGS; i++) begin
                r_regs[i] <= 16'h0000;
            end
        end else begin
            r_state      <= w_state_nxt;
            r_ack        <= (w_state_nxt == ST_DONE);
            r_reg_wr_stb <= 1'b0;
            if (w_sel) begin
                r_reg_idx <= bus.din[7:0];
            end
            if (w_wreg && w_reg_ok) begin
                r_reg_wr_stb <= 1'b1;
                r_reg_wr_idx <= r_reg_idx;
            end
            for (int i = 0; i < NREGS; i++) begin
                if (w_wreg && (r_reg_idx == 8'(i))) begin
                    r_regs[i] <= bus.din;
                end
            end
            if (w_setp) begin
                r_ptr <= bus.din[AW-1:0];
            end
            if (w_wram) begin
                r_ptr <= r_ptr + PTR_ONE;
            end
            if (w_rd) begin
                r_cnt    <= 3'd1;
                r_rd_inc <= bus.op_read_ram_l;
            end
            // r_cnt reaches RD_LAT exactly in the cycle VRAM data is valid.
            if (r_state == ST_RDWAIT) begin
                if (r_cnt == LAT_W) begin
                    r_dout <= i_vram_din;
                    if (r_rd_inc) begin
                        r_ptr <= r_ptr + PTR_ONE;
                    end
                end else begin
                    r_cnt <= r_cnt + 3'd1;
                end
            end
        end
    end

    for (genvar g = 0; g < NREGS; g++) begin : g_flat
        assign o_reg_file[16*g +: 16] = r_regs[g];
    end

    assign bus.ack      = r_ack;
    assign bus.dout     = r_dout;
    assign o_reg_wr_stb = r_reg_wr_stb;
    assign o_reg_wr_idx = r_reg_wr_idx;
    assign o_vram_addr  = r_ptr;
    assign o_vram_we    = w_wram;
    assign o_vram_rd    = w_rd;
    assign o_vram_dout  = w_wram ? bus.din : 16'h0000;

endmodule

// File: tb/tb_gp9001_cpu_port.sv
// tb/tb_gp9001_cpu_port.sv - directed scoreboard bench for gp9001_cpu_port
module tb_gp9001_cpu_port;
    localparam int NREGS  = 16;
    localparam int AW     = 14;
    localparam int RD_LAT = 2;

    localparam logic [5:0] OP_NONE = 6'b000000;
    localparam logic [5:0] OP_SEL  = 6'b000001;
    localparam logic [5:0] OP_WREG = 6'b000010;
    localparam logic [5:0] OP_SETP = 6'b000100;
    localparam logic [5:0] OP_WRAM = 6'b001000;
    localparam logic [5:0] OP_RDH  = 6'b010000;
    localparam logic [5:0] OP_RDL  = 6'b100000;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    gp9001_cpu_port_if bus ();

    logic [16*NREGS-1:0] reg_file;
    logic                stb;
    logic [7:0]          stb_idx_out;
    logic [AW-1:0]       vaddr;
    logic [15:0]         vdout;
    logic [15:0]         vdin;
    logic                we;
    logic                rd;

    gp9001_cpu_port #(.NREGS(NREGS), .AW(AW), .RD_LAT(RD_LAT)) dut (
        .i_clk        (clk),
        .i_reset      (reset),
        .bus          (bus),
        .o_reg_file   (reg_file),
        .o_reg_wr_stb (stb),
        .o_reg_wr_idx (stb_idx_out),
        .o_vram_addr  (vaddr),
        .o_vram_dout  (vdout),
        .o_vram_we    (we),
        .o_vram_rd    (rd),
        .i_vram_din   (vdin)
    );

    // VRAM model with a fixed read latency; 0xDEAD outside the valid-data cycle.
    logic [15:0]   mem [1<<AW];
    bit            pv  [RD_LAT];
    logic [AW-1:0] pa  [RD_LAT];
    logic          pre_en;
    logic [AW-1:0] pre_addr;
    logic [15:0]   pre_data;
    int            we_cnt = 0;
    int            rd_cnt = 0;
    int            stb_cnt = 0;
    int            clash_cnt = 0;
    logic [7:0]    stb_idx = 8'h00;

    always @(posedge clk) begin
        if (we) mem[vaddr] <= vdout;
        if (pre_en) mem[pre_addr] <= pre_data;
        pv[0] <= rd;
        pa[0] <= vaddr;
        for (int k = 1; k < RD_LAT; k++) begin
            pv[k] <= pv[k-1];
            pa[k] <= pa[k-1];
        end
        if (we) we_cnt <= we_cnt + 1;
        if (rd) rd_cnt <= rd_cnt + 1;
        if (we && rd) clash_cnt <= clash_cnt + 1;
        if (stb) begin
            stb_cnt <= stb_cnt + 1;
            stb_idx <= stb_idx_out;
        end
    end

    assign vdin = pv[RD_LAT-1] ? mem[pa[RD_LAT-1]] : 16'hDEAD;

    typedef struct {
        int          lat;
        bit          chk_d;
        logic [15:0] dout;
    } exp_t;

    exp_t        sb [$];
    logic [15:0] exp_regs [NREGS];
    int          checks = 0;
    int          errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_ops(input logic [5:0] m);
        bus.op_select_reg  = m[0];
        bus.op_write_reg   = m[1];
        bus.op_set_ram_ptr = m[2];
        bus.op_write_ram   = m[3];
        bus.op_read_ram_h  = m[4];
        bus.op_read_ram_l  = m[5];
    endtask

    task automatic check_regs(input string tag);
        for (int i = 0; i < NREGS; i++) begin
            chk($sformatf("%s_reg%0d", tag, i), 32'(reg_file[16*i +: 16]), 32'(exp_regs[i]));
        end
    endtask

    task automatic bus_op(input string tag, input logic [5:0] ops, input logic [15:0] d,
                          input int lat, input bit chk_d, input logic [15:0] xd);
        exp_t e;
        int   n;
        bit   got;
        e.lat = lat;
        e.chk_d = chk_d;
        e.dout = xd;
        sb.push_back(e);
        bus.cs  = 1'b1;
        bus.din = d;
        set_ops(ops);
        n   = 0;
        got = 1'b0;
        while (!got && n < 20) begin
            @(negedge clk);
            n++;
            if (bus.ack) got = 1'b1;
        end
        bus.cs = 1'b0;
        set_ops(OP_NONE);
        e = sb.pop_front();
        chk({tag, "_ack_seen"}, 32'(got), 32'd1);
        chk({tag, "_latency"}, 32'(n), 32'(e.lat));
        if (e.chk_d) chk({tag, "_dout"}, 32'(bus.dout), 32'(e.dout));
        @(negedge clk);
        chk({tag, "_ack_clear"}, 32'(bus.ack), 32'd0);
    endtask

    initial begin
        int n;
        reset    = 1'b1;
        bus.cs   = 1'b0;
        bus.din  = 16'h0000;
        set_ops(OP_NONE);
        pre_en   = 1'b0;
        pre_addr = '0;
        pre_data = 16'h0000;
        for (int i = 0; i < NREGS; i++) exp_regs[i] = 16'h0000;

        repeat (3) @(negedge clk);
        chk("rst_ack", 32'(bus.ack), 32'd0);
        chk("rst_dout", 32'(bus.dout), 32'd0);
        chk("rst_addr", 32'(vaddr), 32'd0);
        chk("rst_we_rd", 32'({we, rd}), 32'd0);
        chk("rst_stb", 32'({stb, stb_idx_out}), 32'd0);
        check_regs("rst");
        reset = 1'b0;
        @(negedge clk);

        bus_op("sel5", OP_SEL, 16'h0005, 1, 1'b0, 16'h0000);
        bus_op("wreg5", OP_WREG, 16'h1234, 1, 1'b0, 16'h0000);
        exp_regs[5] = 16'h1234;
        check_regs("wreg5");
        chk("wreg5_stb_cnt", 32'(stb_cnt), 32'd1);
        chk("wreg5_stb_idx", 32'(stb_idx), 32'h05);

        bus_op("sel3_hi", OP_SEL, 16'hFF03, 1, 1'b0, 16'h0000);
        bus_op("wreg3", OP_WREG, 16'h0F0F, 1, 1'b0, 16'h0000);
        exp_regs[3] = 16'h0F0F;
        check_regs("wreg3");
        chk("wreg3_stb_cnt", 32'(stb_cnt), 32'd2);
        chk("wreg3_stb_idx", 32'(stb_idx), 32'h03);

        bus_op("setp_top", OP_SETP, 16'h3FFF, 1, 1'b0, 16'h0000);
        chk("setp_top_addr", 32'(vaddr), 32'h3FFF);
        bus_op("wram_a", OP_WRAM, 16'hAAAA, 1, 1'b0, 16'h0000);
        bus_op("wram_5", OP_WRAM, 16'h5555, 1, 1'b0, 16'h0000);
        chk("vram_3fff", 32'(mem[14'h3FFF]), 32'hAAAA);
        chk("vram_0000", 32'(mem[14'h0000]), 32'h5555);
        chk("wrap_ptr", 32'(vaddr), 32'h0001);
        chk("we_cnt", 32'(we_cnt), 32'd2);

        pre_en = 1'b1;
        pre_addr = 14'h0100;
        pre_data = 16'hBEEF;
        @(negedge clk);
        pre_addr = 14'h0101;
        pre_data = 16'hCAFE;
        @(negedge clk);
        pre_en = 1'b0;

        bus_op("setp_hi_bits", OP_SETP, 16'hC100, 1, 1'b0, 16'h0000);
        chk("setp_hi_addr", 32'(vaddr), 32'h0100);
        bus_op("read_h", OP_RDH, 16'h0000, RD_LAT + 1, 1'b1, 16'hBEEF);
        chk("read_h_ptr", 32'(vaddr), 32'h0100);
        bus_op("read_l", OP_RDL, 16'h0000, RD_LAT + 1, 1'b1, 16'hBEEF);
        chk("read_l_ptr", 32'(vaddr), 32'h0101);
        chk("rd_cnt", 32'(rd_cnt), 32'd2);

        bus_op("multi_op", OP_WRAM | OP_RDL, 16'h7777, 1, 1'b0, 16'h0000);
        chk("multi_ptr", 32'(vaddr), 32'h0101);
        chk("multi_we_cnt", 32'(we_cnt), 32'd2);
        chk("multi_rd_cnt", 32'(rd_cnt), 32'd2);
        bus_op("zero_op", OP_NONE, 16'h1111, 1, 1'b0, 16'h0000);
        chk("zero_ptr", 32'(vaddr), 32'h0101);

        bus_op("sel20", OP_SEL, 16'h0020, 1, 1'b0, 16'h0000);
        bus_op("wreg20", OP_WREG, 16'hFFFF, 1, 1'b0, 16'h0000);
        check_regs("wreg20");
        chk("wreg20_stb_cnt", 32'(stb_cnt), 32'd2);

        bus.cs = 1'b1;
        set_ops(OP_RDL);
        @(negedge clk);
        bus.cs = 1'b0;
        set_ops(OP_NONE);
        n = 1;
        while (!bus.ack && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("csdrop_latency", 32'(n), 32'(RD_LAT + 1));
        chk("csdrop_dout", 32'(bus.dout), 32'hCAFE);
        @(negedge clk);
        chk("csdrop_ack_pulse", 32'(bus.ack), 32'd0);
        chk("csdrop_ptr", 32'(vaddr), 32'h0102);

        bus.cs = 1'b1;
        set_ops(OP_RDH);
        @(negedge clk);
        chk("rdwait_no_ack", 32'(bus.ack), 32'd0);
        reset = 1'b1;
        @(negedge clk);
        for (int i = 0; i < NREGS; i++) exp_regs[i] = 16'h0000;
        chk("rst_rdwait_ack", 32'(bus.ack), 32'd0);
        chk("rst_rdwait_ptr", 32'(vaddr), 32'd0);
        chk("rst_rdwait_dout", 32'(bus.dout), 32'd0);
        check_regs("rst_rdwait");
        reset = 1'b0;
        bus.cs = 1'b0;
        set_ops(OP_NONE);
        @(negedge clk);
        chk("post_rst_idle_ack", 32'(bus.ack), 32'd0);
        bus_op("post_rst_sel", OP_SEL, 16'h0007, 1, 1'b0, 16'h0000);
        bus_op("post_rst_wreg", OP_WREG, 16'h00A5, 1, 1'b0, 16'h0000);
        exp_regs[7] = 16'h00A5;
        check_regs("post_rst");

        bus.cs = 1'b1;
        bus.din = 16'h0123;
        set_ops(OP_SETP);
        @(negedge clk);
        chk("ackhi_ack", 32'(bus.ack), 32'd1);
        chk("ackhi_ptr", 32'(vaddr), 32'h0123);
        reset = 1'b1;
        @(negedge clk);
        chk("rst_ackhi_ack", 32'(bus.ack), 32'd0);
        chk("rst_ackhi_ptr", 32'(vaddr), 32'd0);
        reset = 1'b0;
        bus.cs = 1'b0;
        set_ops(OP_NONE);
        @(negedge clk);
        for (int i = 0; i < NREGS; i++) exp_regs[i] = 16'h0000;
        check_regs("rst_ackhi");
        bus_op("final_setp", OP_SETP, 16'h0042, 1, 1'b0, 16'h0000);
        chk("final_ptr", 32'(vaddr), 32'h0042);
        chk("we_rd_exclusive", 32'(clash_cnt), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
